vga_text_writer: RTL
====================

// Module: vga_text_writer
// PURPOSE
//  Terminal-style front end for vgachargen's character-map write port.
//  - Consumes a byte stream (valid/ready) and tracks a text cursor.
//  - Turns printable bytes and control codes into char_map write cycles
//    (addr/ce/we/be/wdata); 32-bit map word = 4 characters.
//  - Sits directly upstream of vgachargen in the system clock domain.
//  - Fills the whole screen with blanks after reset and on form feed.
// PARAMETERS
//  COLS        80     characters per row (640 px / 8)
//  ROWS        30     rows (480 px / 16); COLS*ROWS must be divisible by 4
//  CLEAR_CHAR  8'h20  fill code used by screen clear
//  (localparams) CHARS=COLS*ROWS; WORDS=CHARS/4; AW=$clog2(WORDS)=10
// PORTS
//  clk_i            in   1   system clock, single clock domain
//  rst_i            in   1   reset, synchronous, active-high
//  ch_valid_i       in   1   input byte valid
//  ch_data_i        in   8   input byte (ASCII)
//  ch_ready_o       out  1   block can accept a byte this cycle
//  char_map_addr_o  out  AW  word address to vgachargen char map
//  char_map_ce_o    out  1   char map chip enable (one-cycle strobe)
//  char_map_we_o    out  1   char map write enable (always equal to ce)
//  char_map_be_o    out  4   byte enables; bit k = character 4*addr+k
//  char_map_wdata_o out  32  write data, byte replicated in all four lanes
//  cursor_col_o     out  7   current cursor column 0..COLS-1
//  cursor_row_o     out  5   current cursor row 0..ROWS-1
//  busy_o           out  1   screen clear in progress
// BEHAVIOUR
//  - All outputs registered.
//  - Reset (rst_i high): ready=0, ce=we=0, addr=0, be=0, wdata=0,
//    cursor=(0,0), busy=1. State goes to CLEAR with clear counter 0.
//  - FSM states IDLE and CLEAR. No other states.
//  - CLEAR: one write per cycle. addr=counter, be=4'hF,
//    wdata={4{CLEAR_CHAR}}, ce=we=1. Counter runs 0..WORDS-1, no gaps.
//    After the last word: ce=0, busy=0, ready=1, state=IDLE.
//    ready=0 for the whole of CLEAR. Cursor is held at (0,0).
//  - IDLE: ready=1. A byte is accepted on valid&ready.
//    Sustained rate is 1 byte/clk.
//  - Printable byte (0x20..0x7E), cursor position pos=row*COLS+col:
//    - The next cycle drives addr=pos>>2, be=1<<pos[1:0],
//      wdata={4{byte}}, ce=we=1 for exactly 1 cycle.
//    - Then col+1. At col=COLS-1: col=0 and row+1.
//    - At row=ROWS-1 the row wraps to 0 (no scrolling).
//  - 0x0A LF: col=0, row+1 (wraps to 0). No write.
//  - 0x0D CR: col=0. No write.
//  - 0x08 BS: col-1 if col>0, else unchanged. No erase, no write.
//  - 0x0C FF: cursor=(0,0), enter CLEAR on the next cycle.
//    ready drops the cycle after acceptance.
//  - Any other byte is consumed and ignored: no write, cursor unchanged.
//  - pos is kept as a running linear pointer (row_base+col).
//    No multiplier is allowed in the datapath.
//  - Cursor outputs update the cycle after acceptance, together with the
//    write strobe.
//  - ce/we with no accepted byte: 0. Unused bytes of wdata still carry
//    the replicated code.
//  - rst_i mid-CLEAR or mid-write aborts the operation. Outputs return to
//    reset values next cycle and a full clear restarts at addr 0.
// TESTING
//  1. Release reset -> exactly 600 consecutive writes, addr 0..599,
//     be=F, wdata=0x20202020; ready rises the cycle after addr 599.
//  2. After clear, send 'A'(0x41) -> addr=0, be=0001, wdata=0x41414141,
//     one-cycle ce/we; cursor=(1,0).
//  3. Cursor (5,1), send 'B' -> addr=21, be=0010 (pos 85);
//     back-to-back 'CDE' -> 3 writes on 3 consecutive cycles.
//  4. Cursor (79,29), send 'Z' -> addr=599, be=1000; cursor=(0,0).
//     LF at row 29 -> (0,0). BS at col 0 -> unchanged.
//  5. Send 0x0C mid-stream with valid held high -> ready low for 600
//     cycles, full clear; next byte written at addr 0 be=0001.
//     0x07 -> no write, cursor unchanged.
//  6. Assert rst_i at clear word 300 -> next clear starts at addr 0 and
//     completes all 600 words.

Source files
------------

// File: rtl/vga_text_writer.sv
// rtl/vga_text_writer.sv - byte stream to character-map writer with text cursor and screen clear
module vga_text_writer #(
    parameter int        COLS       = 80,
    parameter int        ROWS       = 30,
    parameter logic [7:0] CLEAR_CHAR = 8'h20,
    localparam int       CHARS      = COLS * ROWS,
    localparam int       WORDS      = CHARS / 4,
    localparam int       AW         = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ch_valid_i,
    input  logic [7:0]    ch_data_i,
    output logic          ch_ready_o,
    output logic [AW-1:0] char_map_addr_o,
    output logic          char_map_ce_o,
    output logic          char_map_we_o,
    output logic [3:0]    char_map_be_o,
    output logic [31:0]   char_map_wdata_o,
    output logic [6:0]    cursor_col_o,
    output logic [4:0]    cursor_row_o,
    output logic          busy_o
);

    localparam int PW = $clog2(CHARS);
    localparam int CW = $clog2(WORDS + 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    col_q, col_d;
    logic [4:0]    row_q, row_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [PW-1:0] row_base_q, row_base_d;
    logic          ce_q, ce_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          accept;
    logic          last_row;

    assign accept   = ch_valid_i && ready_q;
    assign last_row = (row_q == 5'(ROWS - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        row_d      = row_q;
        pos_d      = pos_q;
        row_base_d = row_base_q;
        ce_d       = 1'b0;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        ready_d    = ready_q;
        busy_d     = busy_q;

        case (state_q)
            CLEAR: begin
                ready_d = 1'b0;
                busy_d  = 1'b1;
                if (cnt_q == CW'(WORDS)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    ce_d    = 1'b1;
                    addr_d  = AW'(cnt_q);
                    be_d    = 4'hF;
                    wdata_d = {4{CLEAR_CHAR}};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (accept) begin
                    if (ch_data_i >= 8'h20 && ch_data_i <= 8'h7E) begin
                        ce_d    = 1'b1;
                        addr_d  = AW'(pos_q >> 2);
                        be_d    = 4'b0001 << pos_q[1:0];
                        wdata_d = {4{ch_data_i}};
                        if (col_q == 7'(COLS - 1)) begin
                            col_d = '0;
                            if (last_row) begin
                                row_d      = '0;
                                row_base_d = '0;
                                pos_d      = '0;
                            end else begin
                                row_d      = row_q + 5'd1;
                                row_base_d = row_base_q + PW'(COLS);
                                pos_d      = pos_q + PW'(1);
                            end
                        end else begin
                            col_d = col_q + 7'd1;
                            pos_d = pos_q + PW'(1);
                        end
                    end else if (ch_data_i == 8'h0A) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d      = '0;
                            row_base_d = '0;
                            pos_d      = '0;
                        end else begin
                            row_d      = row_q + 5'd1;
                            row_base_d = row_base_q + PW'(COLS);
                            pos_d      = row_base_q + PW'(COLS);
                        end
                    end else if (ch_data_i == 8'h0D) begin
                        col_d = '0;
                        pos_d = row_base_q;
                    end else if (ch_data_i == 8'h08) begin
                        if (col_q != 7'd0) begin
                            col_d = col_q - 7'd1;
                            pos_d = pos_q - PW'(1);
                        end
                    end else if (ch_data_i == 8'h0C) begin
                        // Word 0 is written on the acceptance edge so the clear spans exactly WORDS cycles
                        state_d    = CLEAR;
                        col_d      = '0;
                        row_d      = '0;
                        pos_d      = '0;
                        row_base_d = '0;
                        ready_d    = 1'b0;
                        busy_d     = 1'b1;
                        ce_d       = 1'b1;
                        addr_d     = '0;
                        be_d       = 4'hF;
                        wdata_d    = {4{CLEAR_CHAR}};
                        cnt_d      = CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pos_q      <= '0;
            row_base_q <= '0;
            ce_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pos_q      <= pos_d;
            row_base_q <= row_base_d;
            ce_q       <= ce_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign ch_ready_o       = ready_q;
    assign char_map_addr_o  = addr_q;
    assign char_map_ce_o    = ce_q;
    assign char_map_we_o    = ce_q;
    assign char_map_be_o    = be_q;
    assign char_map_wdata_o = wdata_q;
    assign cursor_col_o     = col_q;
    assign cursor_row_o     = row_q;
    assign busy_o           = busy_q;

endmodule
